// File: rtl/instruction_loader_pkg.sv
// Shared types and default widths for the switch-programmed instruction memory.
package instruction_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instruction_loader_input_sync_debounce.sv
// Synchroniser chain, stability debouncer and rising-edge detector for a
// mechanical push-button; rise_o is a single-cycle pulse per accepted press.
module input_sync_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   prev_q, prev_d;
  logic                   sync_out_s;

  assign sync_out_s = sync_q[SYNC_STAGES-1];

  // Accept a new level only after the synced input has differed from the
  // accepted level for DEBOUNCE consecutive samples; any bounce restarts it.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    level_d = level_q;
    cnt_d   = cnt_q;
    prev_d  = level_q;
    if (sync_out_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
      level_d = sync_out_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/instruction_loader.sv
// Instruction memory loaded from board switches and a push-button; holds the
// CPU in clear while loading and serves instructions combinationally in RUN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       DEBOUNCE    = 4,
  parameter logic [DATA_W-1:0] FILL        = '0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load_mode,
  input  logic              write_strobe,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_clear,
  output logic [ADDR_W:0]   load_count,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_t          state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   cpu_clear_q, cpu_clear_d;
  logic [SYNC_STAGES-1:0] lm_sync_q, lm_sync_d;
  logic                   lm_sync_s;
  logic                   wr_pulse_s;
  logic                   mem_we_s;
  logic                   full_s;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  input_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE)
  ) u_strobe (
    .clk    (clock),
    .rst_n  (clear),
    .din    (write_strobe),
    .rise_o (wr_pulse_s)
  );

  assign lm_sync_d = {lm_sync_q[SYNC_STAGES-2:0], load_mode};
  assign lm_sync_s = lm_sync_q[SYNC_STAGES-1];
  assign full_s    = count_q[ADDR_W];

  // Next-state and load bookkeeping; a write taken in the same cycle the
  // switch drops still lands before the move to RUN.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (lm_sync_s) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (wr_pulse_s && !full_s) begin
          mem_we_s = 1'b1;
          ptr_d    = ptr_q + ADDR_W'(1);
          count_d  = count_q + (ADDR_W + 1)'(1);
        end else if (wr_pulse_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (!lm_sync_s) begin
          state_d = RUN;
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (lm_sync_s) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cpu_clear_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      cpu_clear_q <= 1'b0;
      lm_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      cpu_clear_q <= cpu_clear_d;
      lm_sync_q   <= lm_sync_d;
    end
  end

  // Program storage is deliberately not reset so a reset keeps loaded words.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[ptr_q] <= data_in;
    end
  end

  always_comb begin
    if (state_q == RUN) begin
      instruction = mem_q[read_address];
    end else begin
      instruction = FILL;
    end
  end

  assign cpu_clear  = cpu_clear_q;
  assign load_count = count_q;
  assign full       = full_s;
  assign overflow   = ovf_q;

endmodule
